// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the uart_tx byte-stream arbiter.
// State encoding, default parameter values and the index-width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } uart_arb_state_t;

    localparam int UART_ARB_N_REQ          = 2;
    localparam int UART_ARB_TIMEOUT_CYCLES = 12000;

    // A single requester still needs a 1-bit index field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and serializer-side handshake bundle of uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = UART_ARB_N_REQ
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*8-1:0] req_byte;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_dv;
    logic [7:0]         tx_byte;
    logic               tx_active;
    logic               tx_done;

    modport slave (
        input  req_valid, req_byte, req_last, tx_active, tx_done,
        output req_ready, tx_dv, tx_byte
    );

    modport master (
        output req_valid, req_byte, req_last, tx_active, tx_done,
        input  req_ready, tx_dv, tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker with an optional lock onto one index.
// Search order starts at (ptr+1) mod N_REQ; when locked only lock_idx may win.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = UART_ARB_N_REQ,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_lock,
    input  logic [IDX_W-1:0] i_lock_idx,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    // Winner selection: locked owner only, otherwise first valid after ptr.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        if (i_lock) begin
            if (i_req[i_lock_idx]) begin
                o_grant[i_lock_idx] = 1'b1;
                o_idx               = i_lock_idx;
            end else begin
                o_grant = '0;
            end
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                w_cand = IDX_W'((int'(i_ptr) + k) % N_REQ);
                if (!w_found && i_req[w_cand]) begin
                    w_found         = 1'b1;
                    o_grant[w_cand] = 1'b1;
                    o_idx           = w_cand;
                end else begin
                    w_found = w_found;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between N_REQ byte requesters, one byte per frame.
// Optional WAIT_DONE watchdog is built when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ          = UART_ARB_N_REQ,
    parameter  int TIMEOUT_CYCLES = UART_ARB_TIMEOUT_CYCLES,
    localparam int IDX_W          = idx_width(N_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus,
    output logic [IDX_W-1:0]  grant_id,
    output logic              busy,
    output logic              timeout_err
);

    uart_arb_state_t  r_state;
    uart_arb_state_t  w_state_nxt;
    logic [7:0]       r_tx_byte;
    logic [IDX_W-1:0] r_grant_id;
    logic [IDX_W-1:0] r_ptr;
    logic             r_lock;

    logic [N_REQ-1:0] w_pick_req;
    logic [N_REQ-1:0] w_grant;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_accept;
    logic [7:0]       w_sel_byte;
    logic             w_sel_last;
    logic             w_timeout;

    // Nobody may win while uart_tx is still shifting a frame (e.g. across a reset).
    assign w_pick_req = ((r_state == IDLE) && !bus.tx_active) ? bus.req_valid : '0;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req      (w_pick_req),
        .i_ptr      (r_ptr),
        .i_lock     (r_lock),
        .i_lock_idx (r_grant_id),
        .o_grant    (w_grant),
        .o_idx      (w_pick_idx)
    );

    assign w_accept      = |w_grant;
    assign bus.req_ready = w_grant;

    // One-hot mux of the winning requester's byte and packet-end flag.
    always_comb begin
        w_sel_byte = 8'h00;
        w_sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_byte = bus.req_byte[8*i +: 8];
                w_sel_last = bus.req_last[i];
            end else begin
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ISSUE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.tx_done || w_timeout) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture the accepted byte/owner; a non-final byte locks onto its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_byte  <= 8'h00;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_lock     <= 1'b0;
        end else if (w_accept) begin
            r_tx_byte  <= w_sel_byte;
            r_grant_id <= w_pick_idx;
            r_ptr      <= w_pick_idx;
            r_lock     <= ~w_sel_last;
        end else if (w_timeout) begin
            r_lock     <= 1'b0;
        end else begin
            r_lock     <= r_lock;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_timeout_err;

    assign w_timeout = (r_state == WAIT_DONE) && !bus.tx_done &&
                       (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts cycles spent in WAIT_DONE; the error flag is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == WAIT_DONE) begin
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
            r_timeout_err <= r_timeout_err | w_timeout;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign bus.tx_dv   = (r_state == ISSUE);
    assign bus.tx_byte = r_tx_byte;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart_tx and requester-FIFO model.
// Covers reset, single byte, round-robin, packet lock, done/valid overlap, mid reset, watchdog.
module tb_uart_tx_arbiter;

    localparam int FRAME = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [0:0] grant_id;
    logic       busy;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] issued[$];
    logic       um_en = 1'b1;
    logic       um_busy = 1'b0;
    int         um_cnt = 0;
    logic [1:0] hold = 2'b00;
    logic [1:0] prev_fire = 2'b00;
    logic       arm1 = 1'b0;
    logic [7:0] arm_val = 8'h00;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(2)) bus ();

    uart_tx_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(50)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic present();
        bus.req_valid[0] = (q0.size() > 0) && !hold[0];
        bus.req_valid[1] = (q1.size() > 0) && !hold[1];
        if (q0.size() > 0) begin
            bus.req_byte[7:0] = q0[0][7:0];
            bus.req_last[0]   = q0[0][8];
        end else begin
            bus.req_byte[7:0] = 8'h00;
            bus.req_last[0]   = 1'b0;
        end
        if (q1.size() > 0) begin
            bus.req_byte[15:8] = q1[0][7:0];
            bus.req_last[1]    = q1[0][8];
        end else begin
            bus.req_byte[15:8] = 8'h00;
            bus.req_last[1]    = 1'b0;
        end
    endtask

    // One clock: retire transferred bytes, run the uart model, re-present requesters.
    task automatic cyc();
        @(negedge clk);
        if (prev_fire[0] && q0.size() > 0) void'(q0.pop_front());
        if (prev_fire[1] && q1.size() > 0) void'(q1.pop_front());
        if (bus.tx_dv === 1'b1) issued.push_back(bus.tx_byte);
        if (um_en) begin
            bus.tx_done = 1'b0;
            if (bus.tx_dv === 1'b1) begin
                um_busy = 1'b1;
                um_cnt = FRAME;
                bus.tx_active = 1'b1;
            end else if (um_busy) begin
                um_cnt--;
                if (um_cnt == 0) begin
                    bus.tx_done = 1'b1;
                    bus.tx_active = 1'b0;
                    um_busy = 1'b0;
                    if (arm1) begin
                        q1.push_back({1'b1, arm_val});
                        arm1 = 1'b0;
                    end
                end
            end
        end
        present();
        #1;
        prev_fire = bus.req_valid & bus.req_ready;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete(); issued.delete();
        hold = 2'b00; prev_fire = 2'b00; arm1 = 1'b0;
        um_en = 1'b1; um_busy = 1'b0; um_cnt = 0;
        bus.tx_active = 1'b0; bus.tx_done = 1'b0;
        present();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic drain(input int n, input int max_cyc);
        int k;
        k = 0;
        while ((issued.size() < n || busy || um_busy) && k < max_cyc) begin
            cyc();
            k++;
        end
        total++;
        if (k >= max_cyc) begin
            bad++;
            $display("FAIL drain_timeout: issued %0d bytes, needed %0d", issued.size(), n);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        bus.tx_active = 1'b0; bus.tx_done = 1'b0;
        present();
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.tx_dv !== 1'b0) begin bad++; $display("FAIL rst_tx_dv: got %b want 0", bus.tx_dv); end
        total++; if (bus.tx_byte !== 8'h00) begin bad++; $display("FAIL rst_tx_byte: got %h want 00", bus.tx_byte); end
        total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL rst_grant_id: got %b want 0", grant_id); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
        q0.push_back({1'b1, 8'h01}); q1.push_back({1'b1, 8'h02});
        present(); #1;
        total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL rst_ready_rr: got %b want 10", bus.req_ready); end
        bus.tx_active = 1'b1; #1;
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready_active: got %b want 00", bus.req_ready); end
        do_reset();
    endtask

    task automatic test_single();
        int k;
        do_reset();
        q0.push_back({1'b1, 8'h41}); q0.push_back({1'b1, 8'h55});
        cyc();
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_ready_idle: got %b want 01", bus.req_ready); end
        cyc();
        total++; if (bus.tx_dv !== 1'b1 || bus.tx_byte !== 8'h41) begin bad++; $display("FAIL single_issue: got dv=%b byte=%h want dv=1 byte=41", bus.tx_dv, bus.tx_byte); end
        total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL single_grant: got %b want 0", grant_id); end
        k = 0;
        while (k < 20) begin
            cyc();
            k++;
            total++;
            if (bus.req_ready !== 2'b00 || bus.tx_dv !== 1'b0) begin
                bad++; $display("FAIL single_wait: got ready=%b dv=%b want 00/0", bus.req_ready, bus.tx_dv);
            end
            if (bus.tx_done === 1'b1) break;
        end
        total++; if (k >= 20) begin bad++; $display("FAIL single_done_timeout: no tx_done within 20 cycles"); end
        cyc();
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_ready_after_done: got %b want 01", bus.req_ready); end
        total++; if (issued.size() != 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", issued.size()); end
        drain(2, 40);
        total++; if (issued.size() != 2 || issued[1] !== 8'h55) begin bad++; $display("FAIL single_second: got n=%0d want 2 ending 55", issued.size()); end
    endtask

    task automatic test_round_robin();
        logic [7:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back({1'b1, 8'h10});
            q1.push_back({1'b1, 8'h20});
        end
        drain(4, 80);
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 8'h20 : 8'h10;
            total++;
            if (issued.size() <= i || issued[i] !== want) begin
                bad++; $display("FAIL rr_order[%0d]: got %h want %h", i, (issued.size() > i) ? issued[i] : 8'hxx, want);
            end
        end
    endtask

    task automatic test_lock();
        int k;
        logic [7:0] want[4];
        want[0] = 8'hA1; want[1] = 8'hA2; want[2] = 8'hA3; want[3] = 8'hB1;
        do_reset();
        q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
        cyc();
        cyc();
        q1.push_back({1'b1, 8'hB1});
        k = 0;
        while (issued.size() < 2 && k < 40) begin cyc(); k++; end
        hold[0] = 1'b1;
        k = 0;
        while (busy && k < 40) begin cyc(); k++; end
        total++; if (k >= 40) begin bad++; $display("FAIL lock_reach_idle: busy still %b", busy); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            total++;
            if (bus.req_ready !== 2'b00 || busy !== 1'b0) begin
                bad++; $display("FAIL lock_hold[%0d]: got ready=%b busy=%b want 00/0", i, bus.req_ready, busy);
            end
        end
        hold[0] = 1'b0;
        drain(4, 80);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (issued.size() <= i || issued[i] !== want[i]) begin
                bad++; $display("FAIL lock_order[%0d]: got %h want %h", i, (issued.size() > i) ? issued[i] : 8'hxx, want[i]);
            end
        end
    endtask

    task automatic test_done_coincide();
        int k;
        do_reset();
        arm_val = 8'h5A;
        arm1 = 1'b1;
        q0.push_back({1'b1, 8'h33});
        k = 0;
        while (bus.tx_done !== 1'b1 && k < 20) begin cyc(); k++; end
        total++; if (busy !== 1'b1 || bus.req_ready !== 2'b00) begin bad++; $display("FAIL coincide_wait: got busy=%b ready=%b want 1/00", busy, bus.req_ready); end
        cyc();
        total++; if (busy !== 1'b0 || bus.req_ready !== 2'b10) begin bad++; $display("FAIL coincide_next: got busy=%b ready=%b want 0/10", busy, bus.req_ready); end
        cyc();
        total++; if (bus.tx_dv !== 1'b1 || bus.tx_byte !== 8'h5A || grant_id !== 1'b1) begin
            bad++; $display("FAIL coincide_issue: got dv=%b byte=%h id=%b want 1/5a/1", bus.tx_dv, bus.tx_byte, grant_id);
        end
        drain(2, 40);
    endtask

    task automatic test_reset_mid();
        do_reset();
        q0.push_back({1'b0, 8'h77});
        cyc();
        cyc();
        um_en = 1'b0;
        rst_n = 1'b0;
        q0.delete(); prev_fire = 2'b00;
        q1.push_back({1'b1, 8'h66});
        present();
        #1;
        total++; if (bus.tx_dv !== 1'b0 || bus.tx_byte !== 8'h00) begin bad++; $display("FAIL mid_rst_tx: got dv=%b byte=%h want 0/00", bus.tx_dv, bus.tx_byte); end
        total++; if (busy !== 1'b0 || grant_id !== 1'b0) begin bad++; $display("FAIL mid_rst_state: got busy=%b id=%b want 0/0", busy, grant_id); end
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL mid_rst_ready: got %b want 00", bus.req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if (bus.req_ready !== 2'b00 || busy !== 1'b0) begin
                bad++; $display("FAIL mid_rst_blocked[%0d]: got ready=%b busy=%b want 00/0", i, bus.req_ready, busy);
            end
        end
        bus.tx_active = 1'b0; um_en = 1'b1; um_busy = 1'b0;
        #1;
        prev_fire = bus.req_valid & bus.req_ready;
        total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL mid_rst_release: got %b want 10", bus.req_ready); end
        cyc();
        total++; if (bus.tx_dv !== 1'b1 || bus.tx_byte !== 8'h66) begin bad++; $display("FAIL mid_rst_issue: got dv=%b byte=%h want 1/66", bus.tx_dv, bus.tx_byte); end
        drain(1, 40);
    endtask

    task automatic test_timeout();
        do_reset();
        um_en = 1'b0;
        q0.push_back({1'b1, 8'h99});
        cyc();
        cyc();
        total++; if (bus.tx_dv !== 1'b1) begin bad++; $display("FAIL to_issue: got dv=%b want 1", bus.tx_dv); end
        cyc();
`ifdef UART_TX_ARB_TIMEOUT_EN
        for (int i = 1; i <= 49; i++) begin
            cyc();
            total++;
            if (busy !== 1'b1 || timeout_err !== 1'b0) begin
                bad++; $display("FAIL to_window[%0d]: got busy=%b err=%b want 1/0", i, busy, timeout_err);
            end
        end
        cyc();
        total++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin bad++; $display("FAIL to_expire: got busy=%b err=%b want 0/1", busy, timeout_err); end
        repeat (3) cyc();
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
`else
        for (int i = 1; i <= 60; i++) begin
            cyc();
            total++;
            if (busy !== 1'b1 || timeout_err !== 1'b0) begin
                bad++; $display("FAIL nto_wait[%0d]: got busy=%b err=%b want 1/0", i, busy, timeout_err);
            end
        end
        bus.tx_done = 1'b1;
        cyc();
        bus.tx_done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nto_done: got busy=%b want 0", busy); end
`endif
        do_reset();
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_reset_clear: got %b want 0", timeout_err); end
    endtask

    initial begin
        bus.req_valid = 2'b00; bus.req_byte = 16'h0000; bus.req_last = 2'b00;
        bus.tx_active = 1'b0; bus.tx_done = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_done_coincide();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
